// File: rtl/xip_pkg.sv
// xip_pkg: opcodes, responder FSM states and status bits shared by the SPI flash responder.
package xip_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PROGRAM   = 8'h02;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_JEDEC     = 8'h9F;

    localparam int ST_BUSY = 0;
    localparam int ST_WEL  = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STATUS, S_ID, S_IGNORE
    } state_t;

    // Program without WEL is treated like an unknown opcode.
    function automatic state_t cmd_next(input logic [7:0] opc, input logic wel_set);
        return (opc == OP_READ || opc == OP_FAST_READ) ? S_ADDR :
               (opc == OP_PROGRAM && wel_set)          ? S_ADDR :
               (opc == OP_RDSR)                        ? S_STATUS :
               (opc == OP_JEDEC)                       ? S_ID : S_IGNORE;
    endfunction

endpackage

// File: rtl/xip_spi_sync.sv
// xip_spi_sync: 2-flop synchronizers for SCK/SS/MOSI plus registered edge pulses.
module xip_spi_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_pin,
    input  logic ss_pin,
    input  logic mosi_pin,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_low,
    output logic mosi
);

    logic [2:0] sck_q, ss_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q    <= '0;
            ss_q     <= '1;
            mosi_q   <= '0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            ss_fall  <= 1'b0;
            ss_rise  <= 1'b0;
        end else begin
            sck_q    <= {sck_q[1:0], sck_pin};
            ss_q     <= {ss_q[1:0], ss_pin};
            mosi_q   <= {mosi_q[0], mosi_pin};
            sck_rise <= sck_q[1] & ~sck_q[2];
            sck_fall <= ~sck_q[1] & sck_q[2];
            ss_fall  <= ~ss_q[1] & ss_q[2];
            ss_rise  <= ss_q[1] & ~ss_q[2];
        end
    end

    assign ss_low = ~ss_q[2];
    assign mosi   = mosi_q[1];

endmodule

// File: rtl/xip_flash_responder.sv
// xip_flash_responder: SPI flash device front end (W25Q64 subset) backed by an OBI master port.
module xip_flash_responder
    import xip_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4017
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        spi_clk_i,
    input  logic        spi_ss_i,
    input  logic        spi_dq0_i,
    output logic        spi_dq1_o,
    output logic        spi_dq1_oe_o,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] data_i,
    output logic        underrun_o
);

    logic sck_rise, sck_fall, ss_fall, ss_rise, ss_low, mosi;
    state_t state, state_nx;
    logic [5:0] cnt;
    logic [6:0] sh, tx;
    logic [7:0] rx, op, load, status;
    logic [23:0] addr;
    logic [21:0] raddr;
    logic [31:0] rbuf;
    logic [1:0] idx;
    logic bvalid, rd_want, rd_wait, rd_drop, wel, busy, tx_state;

    xip_spi_sync u_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sck_pin  (spi_clk_i),
        .ss_pin   (spi_ss_i),
        .mosi_pin (spi_dq0_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .ss_low   (ss_low),
        .mosi     (mosi)
    );

    assign rx       = {sh, mosi};
    assign busy     = req_o & we_o;
    assign tx_state = state inside {S_RDATA, S_STATUS, S_ID};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ss_rise) state_nx = S_IDLE;
        else if (state == S_IDLE) state_nx = ss_fall ? S_CMD : S_IDLE;
        else if (sck_rise) begin
            case (state)
                S_CMD:   if (cnt == 6'd7) state_nx = cmd_next(rx, wel);
                S_ADDR:  if (cnt == 6'd31) state_nx = (op == OP_FAST_READ) ? S_DUMMY :
                                                      (op == OP_READ) ? S_RDATA : S_WDATA;
                S_DUMMY: if (cnt == 6'd39) state_nx = S_RDATA;
                default: ;
            endcase
        end
    end

    always_comb spi_dq1_oe_o = ss_low && tx_state;

    always_comb begin
        status          = '0;
        status[ST_BUSY] = busy;
        status[ST_WEL]  = wel;
        load = (state == S_RDATA)  ? (bvalid ? rbuf[{addr[1:0], 3'b000} +: 8] : 8'hFF) :
               (state == S_STATUS) ? status :
               (idx == 2'd0)       ? JEDEC_ID[23:16] :
               (idx == 2'd1)       ? JEDEC_ID[15:8] :
               (idx == 2'd2)       ? JEDEC_ID[7:0] : 8'h00;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_o      <= 1'b0;
            we_o       <= 1'b0;
            be_o       <= '0;
            addr_o     <= '0;
            data_o     <= '0;
            spi_dq1_o  <= 1'b0;
            underrun_o <= 1'b0;
            cnt        <= '0;
            sh         <= '0;
            tx         <= '0;
            op         <= '0;
            addr       <= '0;
            raddr      <= '0;
            rbuf       <= '0;
            idx        <= '0;
            bvalid     <= 1'b0;
            rd_want    <= 1'b0;
            rd_wait    <= 1'b0;
            rd_drop    <= 1'b0;
            wel        <= 1'b0;
        end else begin
            if (req_o && gnt_i) begin
                req_o   <= 1'b0;
                rd_wait <= !we_o;
            end
            if (rvalid_i && rd_wait) begin
                rd_wait <= 1'b0;
                rd_drop <= 1'b0;
                if (!rd_drop) begin
                    rbuf   <= data_i;
                    bvalid <= 1'b1;
                end
            end
            if (rd_want && !req_o && !rd_wait) begin
                req_o   <= 1'b1;
                we_o    <= 1'b0;
                be_o    <= 4'hF;
                addr_o  <= BASE_ADDR + {8'h0, raddr, 2'b00};
                rd_want <= 1'b0;
            end
            if (ss_fall) begin
                cnt        <= '0;
                op         <= '0;
                idx        <= '0;
                underrun_o <= 1'b0;
            end
            // A read still on the bus when SS rises must not land in the buffer.
            if (ss_rise) begin
                rd_want <= 1'b0;
                bvalid  <= 1'b0;
                rd_drop <= (rd_wait & ~rvalid_i) | (req_o & ~we_o);
                if (op == OP_PROGRAM) wel <= 1'b0;
            end
            if (sck_rise && state != S_IDLE) begin
                sh  <= rx[6:0];
                cnt <= cnt + 6'd1;
                if (state == S_CMD && cnt == 6'd7) begin
                    op  <= rx;
                    wel <= (rx == OP_WREN) ? 1'b1 : (rx == OP_WRDI) ? 1'b0 : wel;
                end
                if (state == S_ADDR) begin
                    addr <= {addr[22:0], mosi};
                    if (cnt == 6'd31 && op != OP_PROGRAM) begin
                        raddr   <= addr[22:1];
                        rd_want <= 1'b1;
                        bvalid  <= 1'b0;
                    end
                end
                if (state == S_WDATA && cnt[2:0] == 3'd7) begin
                    addr[7:0] <= addr[7:0] + 8'd1;
                    if (req_o || rd_wait) underrun_o <= 1'b1;
                    else begin
                        req_o  <= 1'b1;
                        we_o   <= 1'b1;
                        be_o   <= 4'b0001 << addr[1:0];
                        addr_o <= BASE_ADDR + {8'h0, addr[23:2], 2'b00};
                        data_o <= {4{rx}};
                    end
                end
            end
            if (sck_fall && tx_state) begin
                if (cnt[2:0] == 3'd0) begin
                    spi_dq1_o <= load[7];
                    tx        <= load[6:0];
                    if (state == S_ID && idx != 2'd3) idx <= idx + 2'd1;
                    if (state == S_RDATA) begin
                        if (!bvalid) underrun_o <= 1'b1;
                        else begin
                            addr <= addr + 24'd1;
                            if (&addr[1:0]) begin
                                raddr   <= addr[23:2] + 22'd1;
                                rd_want <= 1'b1;
                                bvalid  <= 1'b0;
                            end
                        end
                    end
                end else begin
                    spi_dq1_o <= tx[6];
                    tx        <= {tx[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_xip_flash_responder.sv
// tb_xip_flash_responder: directed SPI master plus OBI memory model with scoreboarded MISO bytes and OBI transactions.
module tb_xip_flash_responder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        spi_clk_i = 1'b0, spi_ss_i = 1'b1, spi_dq0_i = 1'b0;
    logic        spi_dq1_o, spi_dq1_oe_o, req_o, we_o, gnt_i, underrun_o;
    logic        rvalid_i = 1'b0;
    logic [3:0]  be_o;
    logic [31:0] addr_o, data_o;
    logic [31:0] data_i = '0;
    logic        gnt_en = 1'b1;

    int checks = 0, errors = 0;
    logic [7:0]  exp_q[$];
    logic [68:0] exp_obi[$];
    logic [68:0] log_q[$];
    int          lg_idx = 0;
    int          oe_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic        p1 = 1'b0;
    logic [31:0] pd = '0;

    xip_flash_responder dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .spi_clk_i    (spi_clk_i),
        .spi_ss_i     (spi_ss_i),
        .spi_dq0_i    (spi_dq0_i),
        .spi_dq1_o    (spi_dq1_o),
        .spi_dq1_oe_o (spi_dq1_oe_o),
        .req_o        (req_o),
        .we_o         (we_o),
        .be_o         (be_o),
        .addr_o       (addr_o),
        .data_o       (data_o),
        .gnt_i        (gnt_i),
        .rvalid_i     (rvalid_i),
        .data_i       (data_i),
        .underrun_o   (underrun_o)
    );

    always #5 clk = ~clk;

    assign gnt_i = req_o & gnt_en;

    // Memory: grant combinationally, read data two cycles after grant.
    always @(posedge clk) begin
        rvalid_i <= p1;
        data_i   <= pd;
        p1       <= 1'b0;
        if (spi_dq1_oe_o) oe_cnt <= oe_cnt + 1;
        if (req_o && gnt_i) begin
            log_q.push_back({we_o, be_o, addr_o, we_o ? data_o : 32'h0});
            if (!we_o) begin
                p1 <= 1'b1;
                pd <= mem.exists(addr_o) ? mem[addr_o] : 32'hDEAD_BEEF;
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_x(input logic b, output logic r);
        spi_dq0_i = b;
        #80 spi_clk_i = 1'b1;
        r = spi_dq1_o;
        #80 spi_clk_i = 1'b0;
    endtask

    task automatic byte_x(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_x(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic send(input logic [7:0] t);
        logic [7:0] r;
        byte_x(t, r);
    endtask

    task automatic get(input string tag);
        logic [7:0] r;
        byte_x(8'h00, r);
        check(tag, {72'h0, r}, {72'h0, exp_q.pop_front()});
    endtask

    task automatic cs_lo();
        @(negedge clk);
        spi_ss_i = 1'b0;
        #160;
    endtask

    task automatic cs_hi();
        #80 spi_ss_i = 1'b1;
        #400;
    endtask

    task automatic rdsr(input logic [7:0] e);
        exp_q.push_back(e);
        cs_lo();
        send(8'h05);
        get("rdsr");
        cs_hi();
    endtask

    task automatic obi_check(input string tag);
        int n;
        #200;
        n = log_q.size() - lg_idx;
        check({tag, "_count"}, 80'(n), 80'(exp_obi.size()));
        foreach (exp_obi[i]) begin
            if (lg_idx < log_q.size()) begin
                check(tag, {11'h0, log_q[lg_idx]}, {11'h0, exp_obi[i]});
                lg_idx++;
            end
        end
        lg_idx = log_q.size();
        exp_obi.delete();
    endtask

    initial begin
        int oe0;
        logic b;
        mem[32'h0000_0100] = 32'h4433_2211;
        mem[32'h0000_0104] = 32'h8877_6655;
        mem[32'h00FF_FFFC] = 32'hDDCC_BBAA;
        mem[32'h0000_0000] = 32'h0403_0201;
        repeat (3) @(negedge clk);
        check("reset", {7'h0, req_o, we_o, be_o, addr_o, data_o, spi_dq1_o, spi_dq1_oe_o, underrun_o}, 80'h0);
        rst_ni = 1'b1;
        #100;

        // Plain read: bytes little-endian within the word, one prefetch.
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_obi.push_back({1'b0, 4'hF, 32'h0000_0100, 32'h0});
        exp_obi.push_back({1'b0, 4'hF, 32'h0000_0104, 32'h0});
        cs_lo();
        send(8'h03); send(8'h00); send(8'h01); send(8'h00);
        repeat (4) get("read");
        cs_hi();
        obi_check("read_obi");

        // Fast read wrapping the 24-bit space.
        exp_q = '{8'hCC, 8'hDD, 8'h01, 8'h02};
        exp_obi.push_back({1'b0, 4'hF, 32'h00FF_FFFC, 32'h0});
        exp_obi.push_back({1'b0, 4'hF, 32'h0000_0000, 32'h0});
        cs_lo();
        send(8'h0B); send(8'hFF); send(8'hFF); send(8'hFE); send(8'h00);
        repeat (4) get("fast_read");
        cs_hi();
        check("fast_underrun", {79'h0, underrun_o}, 80'h0);
        obi_check("fast_obi");

        // Write enable, page program with page wrap, WEL cleared afterwards.
        cs_lo(); send(8'h06); cs_hi();
        rdsr(8'h02);
        exp_obi.push_back({1'b1, 4'b0100, 32'h0000_02FC, 32'hAAAA_AAAA});
        exp_obi.push_back({1'b1, 4'b1000, 32'h0000_02FC, 32'hBBBB_BBBB});
        exp_obi.push_back({1'b1, 4'b0001, 32'h0000_0200, 32'hCCCC_CCCC});
        cs_lo();
        send(8'h02); send(8'h00); send(8'h02); send(8'hFE);
        send(8'hAA); send(8'hBB); send(8'hCC);
        cs_hi();
        obi_check("prog_obi");
        rdsr(8'h00);

        // Program without WEL is ignored and never drives MISO.
        oe0 = oe_cnt;
        cs_lo();
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'hAA);
        cs_hi();
        check("nowel_oe", 80'(oe_cnt - oe0), 80'h0);
        obi_check("nowel_obi");

        exp_q = '{8'hEF, 8'h40, 8'h17, 8'h00};
        cs_lo();
        send(8'h9F);
        repeat (4) get("jedec");
        cs_hi();

        // Abort after 12 address bits, then a clean status read.
        cs_lo();
        send(8'h03); send(8'h00);
        repeat (4) bit_x(1'b1, b);
        cs_hi();
        rdsr(8'h00);
        obi_check("abort_obi");

        // Reset in the middle of a read.
        exp_q.push_back(8'h11);
        cs_lo();
        send(8'h03); send(8'h00); send(8'h01); send(8'h00);
        get("pre_reset");
        repeat (3) bit_x(1'b0, b);
        @(negedge clk);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", {7'h0, req_o, we_o, be_o, addr_o, data_o, spi_dq1_o, spi_dq1_oe_o, underrun_o}, 80'h0);
        spi_ss_i = 1'b1;
        #100 rst_ni = 1'b1;
        #100;
        exp_obi.push_back({1'b0, 4'hF, 32'h0000_0100, 32'h0});
        obi_check("reset_obi");

        // Grant withheld: second program byte dropped, BUSY until grant.
        gnt_en = 1'b0;
        cs_lo(); send(8'h06); cs_hi();
        cs_lo();
        send(8'h02); send(8'h00); send(8'h03); send(8'h00);
        send(8'hAA); send(8'hBB);
        cs_hi();
        check("drop_underrun", {79'h0, underrun_o}, 80'h1);
        check("drop_pending", {10'h0, req_o, we_o, be_o, addr_o, data_o}, {10'h0, 1'b1, 1'b1, 4'b0001, 32'h0000_0300, 32'hAAAA_AAAA});
        rdsr(8'h01);
        check("underrun_clr", {79'h0, underrun_o}, 80'h0);
        gnt_en = 1'b1;
        exp_obi.push_back({1'b1, 4'b0001, 32'h0000_0300, 32'hAAAA_AAAA});
        obi_check("drop_obi");
        rdsr(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
